// File: rtl/ram_rd_if.sv
// Port-B bus between the read sweeper and the dual-port RAM.
interface ram_rd_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          ram_rd_en;
    logic          ram_rd_we;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    modport master (
        output ram_rd_en,
        output ram_rd_we,
        output ram_rd_addr,
        input  ram_rd_data
    );

    modport slave (
        input  ram_rd_en,
        input  ram_rd_we,
        input  ram_rd_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_rd.sv
// Port-B read sweeper and checker: reads 0..DEPTH-1 while rd_flag is high and
// compares every returned word against its own address (the writer's pattern).
module ram_rd #(
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_flag,
    input  logic          chk_clr,
    ram_rd_if.master      ram,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data_o,
    output logic          mismatch,
    output logic          lap_done,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] pass_cnt,
    output logic          busy
);
    localparam int            MW   = (AW < DW) ? AW : DW;
    localparam int            DCW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          state, state_n;
    logic            en_q, en_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [DCW-1:0]  drn_cnt, drn_cnt_n;
    logic            start;

    logic [RD_LAT-1:0] pv;
    logic [AW-1:0]     pa [RD_LAT];

    logic            ret_v;
    logic [AW-1:0]   ret_a;
    logic [DW-1:0]   exp_word;
    logic            ret_mm;
    logic            ret_last;
    logic            lap_fail;

    assign ram.ram_rd_en   = en_q;
    assign ram.ram_rd_addr = addr_q;
    assign ram.ram_rd_we   = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            addr_q  <= '0;
            drn_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            en_q    <= en_n;
            addr_q  <= addr_n;
            drn_cnt <= drn_cnt_n;
            busy    <= (state_n != IDLE);
        end
    end

    // en/addr are computed here as next-cycle values so the port stays registered.
    always_comb begin
        state_n   = state;
        en_n      = 1'b0;
        addr_n    = '0;
        drn_cnt_n = '0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (rd_flag) begin
                    state_n = READ;
                    en_n    = 1'b1;
                    start   = 1'b1;
                end
            end
            READ: begin
                if (rd_flag) begin
                    en_n   = 1'b1;
                    addr_n = (addr_q == LAST) ? '0 : addr_q + 1'b1;
                end else begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (drn_cnt == DCW'(RD_LAT - 1)) begin
                    state_n = IDLE;
                end else begin
                    drn_cnt_n = drn_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Issue pipeline: stage RD_LAT-1 lines up with the word on ram_rd_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= en_q;
            pa[0] <= addr_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign ret_v = pv[RD_LAT-1];
    assign ret_a = pa[RD_LAT-1];

    always_comb begin
        exp_word         = '0;
        exp_word[MW-1:0] = ret_a[MW-1:0];
    end

    assign ret_mm   = ret_v && (ram.ram_rd_data != exp_word);
    assign ret_last = ret_v && (ret_a == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid  <= 1'b0;
            rd_data_o <= '0;
            mismatch  <= 1'b0;
            lap_done  <= 1'b0;
        end else begin
            rd_valid <= ret_v;
            mismatch <= ret_mm;
            lap_done <= ret_last;
            if (ret_v) begin
                rd_data_o <= ram.ram_rd_data;
            end
        end
    end

    // A clear wins over a coincident retirement: that word's count update is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err      <= 1'b0;
            err_cnt  <= '0;
            pass_cnt <= '0;
            lap_fail <= 1'b0;
        end else if (chk_clr) begin
            err      <= 1'b0;
            err_cnt  <= '0;
            pass_cnt <= '0;
            lap_fail <= 1'b0;
        end else begin
            if (ret_mm) begin
                err <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
            if (ret_last) begin
                if (!lap_fail && !ret_mm && (pass_cnt != '1)) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
                lap_fail <= 1'b0;
            end else if (start) begin
                lap_fail <= 1'b0;
            end else if (ret_mm) begin
                lap_fail <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_rd.sv
// Two sweepers (RD_LAT=1/8-bit/64 deep and RD_LAT=3/4-bit/20 deep) driven in
// lockstep; a cycle-stamped queue of expected words is retired by a monitor.
module tb_ram_rd;
    localparam int A_AW = 6, A_DW = 8, A_DEPTH = 64, A_LAT = 1, A_CW = 16;
    localparam int B_AW = 5, B_DW = 4, B_DEPTH = 20, B_LAT = 3, B_CW = 4;

    logic clk = 1'b0, rst = 1'b0, rd_flag = 1'b0, chk_clr = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic clr_seen = 1'b0;
    always @(posedge clk) clr_seen <= chk_clr;

    int checks = 0;
    int errors = 0;

    ram_rd_if #(.AW(A_AW), .DW(A_DW)) bus_a ();
    ram_rd_if #(.AW(B_AW), .DW(B_DW)) bus_b ();

    logic            a_valid, a_mm, a_lap, a_err, a_busy;
    logic [A_DW-1:0] a_data;
    logic [A_CW-1:0] a_errc, a_pass;
    logic            b_valid, b_mm, b_lap, b_err, b_busy;
    logic [B_DW-1:0] b_data;
    logic [B_CW-1:0] b_errc, b_pass;

    ram_rd #(.AW(A_AW), .DW(A_DW), .DEPTH(A_DEPTH), .RD_LAT(A_LAT), .CW(A_CW)) dut_a (
        .clk(clk), .rst(rst), .rd_flag(rd_flag), .chk_clr(chk_clr), .ram(bus_a),
        .rd_valid(a_valid), .rd_data_o(a_data), .mismatch(a_mm), .lap_done(a_lap),
        .err(a_err), .err_cnt(a_errc), .pass_cnt(a_pass), .busy(a_busy)
    );

    ram_rd #(.AW(B_AW), .DW(B_DW), .DEPTH(B_DEPTH), .RD_LAT(B_LAT), .CW(B_CW)) dut_b (
        .clk(clk), .rst(rst), .rd_flag(rd_flag), .chk_clr(chk_clr), .ram(bus_b),
        .rd_valid(b_valid), .rd_data_o(b_data), .mismatch(b_mm), .lap_done(b_lap),
        .err(b_err), .err_cnt(b_errc), .pass_cnt(b_pass), .busy(b_busy)
    );

    // RAM models with the respective read latencies.
    logic [A_DW-1:0] mem_a [A_DEPTH];
    logic [B_DW-1:0] mem_b [32];
    logic [A_DW-1:0] ra = '0;
    logic [B_DW-1:0] rb [B_LAT];

    always @(posedge clk) if (bus_a.ram_rd_en) ra <= mem_a[bus_a.ram_rd_addr];
    assign bus_a.ram_rd_data = ra;

    always @(posedge clk) begin
        rb[0] <= mem_b[bus_b.ram_rd_addr];
        for (int i = 1; i < B_LAT; i++) rb[i] <= rb[i-1];
    end
    assign bus_b.ram_rd_data = rb[B_LAT-1];

    typedef struct {
        int cyc;
        int addr;
        int data;
        bit first;
    } rec_t;
    rec_t qa[$];
    rec_t qb[$];

    int m_errc [2];
    int m_pass [2];
    bit m_err  [2];
    bit m_fail [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic mm, input logic lap,
                       input logic er, input int data, input int errc, input int pass,
                       input logic we);
        rec_t  r;
        bit    have;
        bit    exp_mm;
        bit    last;
        int    depth, dmod, cmax;
        string p;
        depth = (i == 0) ? A_DEPTH : B_DEPTH;
        dmod  = (i == 0) ? (1 << A_DW) : (1 << B_DW);
        cmax  = (i == 0) ? (1 << A_CW) - 1 : (1 << B_CW) - 1;
        p     = (i == 0) ? "A" : "B";
        chk($sformatf("%s.we", p), we, 0);
        if (!rst) begin
            if (i == 0) qa.delete(); else qb.delete();
            m_errc[i] = 0; m_pass[i] = 0; m_err[i] = 0; m_fail[i] = 0;
            chk($sformatf("%s.rst_valid", p), v, 0);
            chk($sformatf("%s.rst_data", p), data, 0);
            chk($sformatf("%s.rst_mismatch", p), mm, 0);
            chk($sformatf("%s.rst_lap", p), lap, 0);
            chk($sformatf("%s.rst_err", p), er, 0);
            chk($sformatf("%s.rst_errcnt", p), errc, 0);
            chk($sformatf("%s.rst_pass", p), pass, 0);
            return;
        end
        have = 0;
        exp_mm = 0;
        last = 0;
        if (i == 0) begin
            if (qa.size() > 0 && qa[0].cyc == cyc) begin r = qa.pop_front(); have = 1; end
        end else begin
            if (qb.size() > 0 && qb[0].cyc == cyc) begin r = qb.pop_front(); have = 1; end
        end
        if (have) begin
            if (r.first) m_fail[i] = 0;
            exp_mm = (r.data != (r.addr % dmod));
            last   = (r.addr == depth - 1);
        end
        if (clr_seen) begin
            m_errc[i] = 0; m_pass[i] = 0; m_err[i] = 0; m_fail[i] = 0;
        end else if (have) begin
            if (exp_mm) begin
                m_err[i] = 1;
                if (m_errc[i] < cmax) m_errc[i]++;
            end
            if (last) begin
                if (!m_fail[i] && !exp_mm && m_pass[i] < cmax) m_pass[i]++;
                m_fail[i] = 0;
            end else if (exp_mm) begin
                m_fail[i] = 1;
            end
        end
        chk($sformatf("%s.rd_valid", p), v, have);
        chk($sformatf("%s.mismatch", p), mm, have && exp_mm);
        chk($sformatf("%s.lap_done", p), lap, have && last);
        if (have) chk($sformatf("%s.rd_data a=%0d", p, r.addr), data, r.data);
        chk($sformatf("%s.err", p), er, m_err[i]);
        chk($sformatf("%s.err_cnt", p), errc, m_errc[i]);
        chk($sformatf("%s.pass_cnt", p), pass, m_pass[i]);
    endtask

    always @(negedge clk) begin
        mon(0, a_valid, a_mm, a_lap, a_err, int'(a_data), int'(a_errc), int'(a_pass), bus_a.ram_rd_we);
        mon(1, b_valid, b_mm, b_lap, b_err, int'(b_data), int'(b_errc), int'(b_pass), bus_b.ram_rd_we);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_idle();
        chk_clr = 1'b1;
        step();
        chk_clr = 1'b0;
        step();
    endtask

    // n words are issued; chk_clr is high for one cycle at iteration clr_k;
    // rst is pulsed when word rst_k is on the bus.
    task automatic session(input int n, input int clr_k, input int rst_k);
        rd_flag = 1'b1;
        for (int k = 0; k < n; k++) begin
            step();
            chk_clr = (k == clr_k);
            if (k == rst_k) begin
                rst = 1'b0;
                rd_flag = 1'b0;
                chk_clr = 1'b0;
                #1;
                chk("A.rst_mid_en", bus_a.ram_rd_en, 0);
                chk("A.rst_mid_addr", bus_a.ram_rd_addr, 0);
                chk("A.rst_mid_busy", a_busy, 0);
                chk("A.rst_mid_valid", a_valid, 0);
                chk("A.rst_mid_pass", a_pass, 0);
                chk("B.rst_mid_en", bus_b.ram_rd_en, 0);
                chk("B.rst_mid_busy", b_busy, 0);
                chk("B.rst_mid_errcnt", b_errc, 0);
                repeat (3) step();
                rst = 1'b1;
                repeat (2) step();
                return;
            end
            chk("A.en", bus_a.ram_rd_en, 1);
            chk("A.addr", bus_a.ram_rd_addr, k % A_DEPTH);
            chk("A.busy", a_busy, 1);
            chk("B.en", bus_b.ram_rd_en, 1);
            chk("B.addr", bus_b.ram_rd_addr, k % B_DEPTH);
            chk("B.busy", b_busy, 1);
            qa.push_back('{cyc + A_LAT + 1, k % A_DEPTH, int'(mem_a[k % A_DEPTH]), k == 0});
            qb.push_back('{cyc + B_LAT + 1, k % B_DEPTH, int'(mem_b[k % B_DEPTH]), k == 0});
        end
        rd_flag = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            chk_clr = 1'b0;
            chk("A.drain_en", bus_a.ram_rd_en, 0);
            chk("A.drain_addr", bus_a.ram_rd_addr, 0);
            chk("A.drain_busy", a_busy, j < A_LAT);
            chk("B.drain_en", bus_b.ram_rd_en, 0);
            chk("B.drain_addr", bus_b.ram_rd_addr, 0);
            chk("B.drain_busy", b_busy, j < B_LAT);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < A_DEPTH; i++) mem_a[i] = A_DW'(i);
        for (int i = 0; i < 32; i++) mem_b[i] = B_DW'(i);
    endtask

    initial begin
        int n, ck;
        fill_pattern();
        // Reset held with rd_flag low.
        repeat (20) begin
            step();
            chk("A.reset_en", bus_a.ram_rd_en, 0);
            chk("A.reset_busy", a_busy, 0);
            chk("B.reset_en", bus_b.ram_rd_en, 0);
            chk("B.reset_busy", b_busy, 0);
        end
        rst = 1'b1;
        repeat (2) step();

        // Clean pattern: one lap, then two more.
        session(64, -1, -1);
        chk("A.pass_after_1_lap", a_pass, 1);
        chk("B.pass_after_64_words", b_pass, 3);
        session(128, -1, -1);
        chk("A.pass_after_3_laps", a_pass, 3);
        chk("A.errcnt_clean", a_errc, 0);
        chk("B.pass_after_192_words", b_pass, 9);

        // Corrupted word at A[10]; B memory all zero.
        mem_a[10] = 8'hFF;
        for (int i = 0; i < 32; i++) mem_b[i] = '0;
        clear_idle();
        session(128, -1, -1);
        chk("A.errcnt_two_laps", a_errc, 2);
        chk("A.err_sticky", a_err, 1);
        chk("A.pass_bad_laps", a_pass, 0);
        chk("B.errcnt_saturated", b_errc, 15);

        // Clear coincides with the retirement of A word 10 and B word 8.
        session(30, 11, -1);
        chk("A.errcnt_after_clr", a_errc, 0);
        chk("A.err_after_clr", a_err, 0);

        // Partial lap then restart from address 0.
        fill_pattern();
        clear_idle();
        session(21, -1, -1);
        chk("A.pass_partial", a_pass, 0);
        session(64, -1, -1);
        chk("A.pass_after_restart", a_pass, 1);

        // Reset mid-lap at address 40, then a clean lap counts from zero.
        session(100, -1, 40);
        session(64, -1, -1);
        chk("A.pass_after_rst", a_pass, 1);
        chk("A.errcnt_after_rst", a_errc, 0);

        // Randomized memory corruption, lengths and clears.
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < A_DEPTH; i++)
                mem_a[i] = ($urandom_range(0, 9) == 0) ? A_DW'($urandom) : A_DW'(i);
            for (int i = 0; i < 32; i++)
                mem_b[i] = ($urandom_range(0, 9) == 0) ? B_DW'($urandom) : B_DW'(i);
            n  = $urandom_range(1, 160);
            ck = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            session(n, ck, -1);
            if ($urandom_range(0, 4) == 0) clear_idle();
        end

        step();
        chk("A.queue_drained", qa.size(), 0);
        chk("B.queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (%0d checks, %0d errors)", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ram_rd.md
Name: ram_rd

Overview:
- Read-port driver and data checker for port B of the dual-port RAM.
- Waits for the write-side start flag, then sweeps addresses 0..DEPTH-1 continuously.
- Compares each returned word against the write pattern (data = address).
- Reports read data, mismatches, and per-lap pass/fail counts to the top level (LEDs/ILA).

Parameters:
- AW, 6, address width
- DW, 8, data width
- DEPTH, 64, words swept per lap (≤ 2**AW)
- RD_LAT, 1, RAM read latency in cycles (legal 1..4)
- CW, 16, width of err_cnt and pass_cnt

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- rd_flag  input  1  start/run level from write side; high = reading permitted
- chk_clr  input  1  synchronous clear of err, err_cnt, pass_cnt
- ram_rd_en  output  1  port B enable
- ram_rd_we  output  1  port B write enable, constant 0
- ram_rd_addr  output  AW  port B address
- ram_rd_data  input  DW  port B read data
- rd_valid  output  1  rd_data_o holds a checked word this cycle
- rd_data_o  output  DW  registered read word
- mismatch  output  1  word in rd_data_o differed from expected (qualified by rd_valid)
- lap_done  output  1  one-cycle pulse when the check of address DEPTH-1 retires
- err  output  1  sticky: any mismatch since reset/clear
- err_cnt  output  CW  total mismatches, saturating
- pass_cnt  output  CW  laps with zero mismatches, saturating
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; address and valid/expected pipelines cleared.
- All outputs registered except ram_rd_we, which is tied 0.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ when rd_flag sampled high. On that same edge: ram_rd_en=1, ram_rd_addr=0.
  - READ: ram_rd_en=1. ram_rd_addr increments each cycle; DEPTH-1 wraps to 0.
  - READ -> DRAIN when rd_flag sampled low. On that edge: ram_rd_en=0, ram_rd_addr=0.
  - DRAIN: holds RD_LAT cycles so in-flight reads retire and are checked, then returns to IDLE.
  - DRAIN -> IDLE only; rd_flag high during DRAIN is ignored until IDLE.
- Latency:
  - Address A is presented with ram_rd_en in cycle c.
  - ram_rd_data is valid in cycle c+RD_LAT and is sampled on the edge ending that cycle.
  - rd_valid, rd_data_o and mismatch are high/valid in cycle c+RD_LAT+1.
  - Issue and check pipelines carry en and A through RD_LAT stages.
- Expected value: A zero-extended to DW if AW<DW, else the low DW bits of A.
  - mismatch = (ram_rd_data != expected), registered with rd_valid.
  - mismatch = 0 whenever rd_valid = 0.
- Error tracking:
  - On a retiring mismatch: err_cnt += 1, holding at 2**CW-1; err set.
  - A per-lap fail bit records any mismatch within the current lap.
- Lap completion:
  - lap_done pulses in the same cycle rd_valid shows address DEPTH-1.
  - If the lap had no mismatch (including that last word), pass_cnt += 1, saturating.
  - The per-lap fail bit then clears for the next lap.
- Partial laps: a lap aborted by DRAIN produces no lap_done and no pass_cnt update. Its mismatches still count in err_cnt/err. The next READ starts at address 0 with the fail bit cleared.
- chk_clr (any state):
  - Clears err, err_cnt, pass_cnt and the fail bit on the next edge.
  - It takes priority over a simultaneous mismatch or lap completion; that event is dropped.
  - It does not affect FSM, address or rd_valid/rd_data_o.
- rst asserted mid-read: immediate return to reset values. The first read after release starts at address 0.

Test Plan:
- Reset with rd_flag=0, 20 cycles -> all outputs 0, busy=0, ram_rd_we=0 throughout.
- Model RAM with RD_LAT=1, mem[i]=i, rd_flag high at edge T:
  - ram_rd_en=1 and addr=0 after T.
  - rd_valid first high 2 cycles later with rd_data_o=0, then 1,2,3…
  - lap_done at addr 63; pass_cnt=1 after first lap, 3 after three laps; err_cnt=0.
- mem[10]=8'hFF, run 2 laps:
  - mismatch high exactly when rd_data_o=FF.
  - err_cnt=2, err=1, pass_cnt=0, lap_done still pulses twice.
- rd_flag dropped with addr=20 in flight:
  - ram_rd_en low next cycle; rd_valid continues through the last issued address, then drops.
  - busy falls RD_LAT cycles after DRAIN entry; no lap_done.
  - Re-raising rd_flag restarts at addr 0.
- RD_LAT=3, CW=4, mem all 0:
  - First rd_valid 4 cycles after ram_rd_en; data checked correctly.
  - err_cnt saturates at 15.
  - chk_clr pulse coinciding with a mismatch -> err_cnt=0, err=0.
- rst pulsed low mid-lap at addr 40 -> outputs zero immediately; after release and rd_flag high, reads resume from addr 0 and pass_cnt counts from 0.
